// File: rtl/alu_result_fifo.sv
// First-word-fall-through buffer for registered ALU mux results.
// Tags each entry with its select code and a zero flag; counts drops.
module alu_result_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_sel,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sel,
  output logic              out_zero,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic [3:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [1:0]        sel;
    logic [DATA_W-1:0] data;
    logic              zero;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       drop_q, drop_d;
  logic             push, pop, drop;

  // Flow control comes only from registered occupancy.
  assign in_ready  = (cnt_q != FULL);
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign drop      = in_valid & ~in_ready;

  assign out_data = mem_q[rd_ptr_q].data;
  assign out_sel  = mem_q[rd_ptr_q].sel;
  assign out_zero = mem_q[rd_ptr_q].zero;
  assign count    = cnt_q;
  assign drop_cnt = drop_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (drop && drop_q != 4'hF) drop_d = drop_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= '{sel: in_sel, data: in_data,
                           zero: (in_data == '0)};
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: vector table plus queue scoreboard.
module tb_alu_result_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic [1:0] in_sel;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_sel;
  logic       out_zero;
  logic       out_ready;
  logic [2:0] count;
  logic [3:0] drop_cnt;

  alu_result_fifo #(.DATA_W(4), .DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_sel(in_sel),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_zero(out_zero), .out_ready(out_ready),
    .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic [1:0] sel;
    logic       zero;
  } ent_t;

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic [1:0] s;
    logic       r;
    int         cnt;
    logic       ov;
    logic       ir;
    int         drp;
    logic [3:0] head;
  } vec_t;

  ent_t sb[$];
  int   drops;
  int   checks;
  int   errors;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  task automatic step(input logic v, input logic [3:0] d,
                      input logic [1:0] s, input logic r,
                      input logic rs);
    ent_t e;
    bit   mpush, mpop;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    out_ready = r;
    rst       = rs;
    #1;
    mpop  = !rs && r && sb.size() > 0;
    mpush = !rs && v && sb.size() < DEPTH;
    if (!rs && v && !mpush && drops < 15) drops++;
    if (mpop) begin
      e = sb.pop_front();
      chk("pop_data", out_data, e.data);
      chk("pop_sel", out_sel, e.sel);
      chk("pop_zero", out_zero, e.zero);
    end
    if (mpush) sb.push_back('{data: d, sel: s, zero: (d == 4'h0)});
    if (rs) begin
      sb.delete();
      drops = 0;
    end
    @(posedge clk);
    #1;
    chk("count", count, sb.size());
    chk("out_valid", out_valid, int'(sb.size() > 0));
    chk("in_ready", in_ready, int'(sb.size() < DEPTH));
    chk("drop_cnt", drop_cnt, drops);
    if (sb.size() > 0) begin
      chk("head_data", out_data, sb[0].data);
      chk("head_sel", out_sel, sb[0].sel);
      chk("head_zero", out_zero, sb[0].zero);
    end
  endtask

  vec_t tbl[15];

  initial begin
    checks = 0;
    errors = 0;
    drops  = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_sel = '0;
    out_ready = 1'b0;

    tbl[0]  = '{0, 4'h0, 2'b00, 0, 0, 0, 1, 0, 4'h0};
    tbl[1]  = '{1, 4'h5, 2'b10, 0, 1, 1, 1, 0, 4'h5};
    tbl[2]  = '{1, 4'h0, 2'b01, 0, 2, 1, 1, 0, 4'h5};
    tbl[3]  = '{0, 4'h0, 2'b00, 1, 1, 1, 1, 0, 4'h0};
    tbl[4]  = '{0, 4'h0, 2'b00, 1, 0, 0, 1, 0, 4'h0};
    tbl[5]  = '{1, 4'h1, 2'b00, 0, 1, 1, 1, 0, 4'h1};
    tbl[6]  = '{1, 4'h2, 2'b01, 0, 2, 1, 1, 0, 4'h1};
    tbl[7]  = '{1, 4'h3, 2'b10, 0, 3, 1, 1, 0, 4'h1};
    tbl[8]  = '{1, 4'h4, 2'b11, 0, 4, 1, 0, 0, 4'h1};
    tbl[9]  = '{1, 4'h9, 2'b00, 0, 4, 1, 0, 1, 4'h1};
    tbl[10] = '{1, 4'hA, 2'b01, 0, 4, 1, 0, 2, 4'h1};
    tbl[11] = '{0, 4'h0, 2'b00, 1, 3, 1, 1, 2, 4'h2};
    tbl[12] = '{0, 4'h0, 2'b00, 1, 2, 1, 1, 2, 4'h3};
    tbl[13] = '{0, 4'h0, 2'b00, 1, 1, 1, 1, 2, 4'h4};
    tbl[14] = '{0, 4'h0, 2'b00, 1, 0, 0, 1, 2, 4'h0};

    step(0, 4'h0, 2'b00, 0, 1);
    step(0, 4'h0, 2'b00, 0, 1);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].r, 0);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("tbl%0d_ov", i), out_valid, tbl[i].ov);
      chk($sformatf("tbl%0d_ir", i), in_ready, tbl[i].ir);
      chk($sformatf("tbl%0d_drop", i), drop_cnt, tbl[i].drp);
      if (tbl[i].ov)
        chk($sformatf("tbl%0d_head", i), out_data, tbl[i].head);
    end

    // Steady push+pop at count 2 walks pointers across the wrap.
    step(1, 4'hB, 2'b01, 0, 0);
    step(1, 4'hC, 2'b10, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 4'(i), 2'(i), 1, 0);
      chk("wrap_count", count, 2);
    end
    for (int i = 0; i < 2; i++) step(0, 4'h0, 2'b00, 1, 0);
    chk("wrap_empty", out_valid, 0);

    // Drop counter saturation.
    step(0, 4'h0, 2'b00, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 4'(i + 1), 2'b11, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 4'hE, 2'b00, 0, 0);
    chk("drop_sat", drop_cnt, 15);
    chk("sat_count", count, 4);

    // Reset in the middle of traffic.
    step(0, 4'h0, 2'b00, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 4'(i + 3), 2'b10, 0, 0);
    step(1, 4'hF, 2'b00, 0, 0);
    step(0, 4'h0, 2'b00, 1, 0);
    chk("pre_rst_count", count, 3);
    chk("pre_rst_drop", drop_cnt, 1);
    step(1, 4'h8, 2'b01, 1, 1);
    chk("rst_count", count, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_drop", drop_cnt, 0);
    step(1, 4'h7, 2'b11, 0, 0);
    chk("post_rst_data", out_data, 7);
    chk("post_rst_sel", out_sel, 3);
    step(0, 4'h0, 2'b00, 1, 0);
    chk("post_rst_empty", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
Downstream stage of the registered 4-bit result mux in the ALU system. Captures each selected ALU result together with the 2-bit select code that produced it, and buffers it in a small first-word-fall-through FIFO. Derives a per-entry zero flag and presents entries to the display/readout logic with a valid/ready handshake. Counts results lost to back-pressure.

Parameters:
DATA_W, 4, result width; equals the mux output width.
DEPTH, 4, FIFO entries; power of two, minimum 2.
CNT_W, 3, occupancy width; equals log2(DEPTH)+1.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  result strobe; the mux select-change strobe delayed one clk (generated at top level), so it aligns with the registered mux output.
in_data  input  DATA_W  registered mux output.
in_sel  input  2  select code that produced in_data; the top level delays it one clk as well.
in_ready  output  1  FIFO can accept; equals not full.
out_valid  output  1  head entry available; equals not empty.
out_data  output  DATA_W  head entry result.
out_sel  output  2  head entry select code.
out_zero  output  1  head entry result equals 0.
out_ready  input  1  consumer accepts head entry.
count  output  CNT_W  current occupancy, 0..DEPTH.
drop_cnt  output  4  results offered while full; saturates at 15.

Behaviour:
- Reset (rst high at a rising edge): read pointer, write pointer, count and drop_cnt go to 0. out_valid=0, in_ready=1. Storage contents are don't-care. Reset overrides any push or pop in the same cycle, including a reset issued mid-stream.
- Push occurs when in_valid and in_ready are both high at an edge. At push, {in_sel, in_data, zero flag} is written to mem[wr_ptr] and wr_ptr advances. The zero flag is computed as in_data==0 at push time.
- Pop occurs when out_valid and out_ready are both high at an edge. At pop, rd_ptr advances.
- FWFT operation: out_data, out_sel and out_zero are read combinationally from mem[rd_ptr]. The first push into an empty FIFO is visible on the outputs with out_valid=1 one cycle after the push edge. There is no bypass path while empty.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count update rules: push only gives +1; pop only gives -1; push and pop together leave count unchanged.
- Full (count==DEPTH): in_ready=0. A simultaneous pop does not reopen in_ready in the same cycle, so no combinational ready path exists. An in_valid while full is dropped: drop_cnt increments, saturates at 15, and the data is discarded.
- Empty (count==0): out_valid=0. out_ready is ignored and there is no underflow. Output data is don't-care.
- Outputs are stable while out_valid=1 and out_ready=0.
- count, drop_cnt, in_ready and out_valid are all derived from registered state only.

Test Plan:
- Reset then idle -> count=0, out_valid=0, in_ready=1, drop_cnt=0.
- Push 4'h5/sel 2'b10, then 4'h0/sel 2'b01 with out_ready=0 -> count=2; head out_data=5, out_sel=2'b10, out_zero=0. Pop once -> out_data=0, out_zero=1, out_sel=2'b01.
- Push 4'h1, 4'h2, 4'h3, 4'h4, then offer 4'h9 and 4'hA -> count=4, in_ready=0, drop_cnt=2. Drain -> values 1,2,3,4 in order, 9 and A never appear.
- Hold count=2 and assert in_valid and out_ready every cycle for 10 cycles with values 0..9 -> count stays 2 and outputs emerge in order. Checks pointer wrap across DEPTH=4.
- Offer 20 pushes while full with out_ready=0 -> drop_cnt saturates at 15.
- Assert rst mid-stream with count=3 and push+pop active -> next cycle count=0, out_valid=0, drop_cnt=0. A subsequent push of 4'h7 reads back as 7.
